// File: rtl/dither_pkg.sv
// Shared types and constants for the dither line scheduler.
package dither_pkg;

   localparam int unsigned FRAME_WIDTH_DEF  = 320;
   localparam int unsigned FRAME_HEIGHT_DEF = 180;
   localparam logic [7:0]  FILL_PIXEL_DEF   = 8'h00;

   localparam int unsigned NUM_LINES = 3;
   localparam int unsigned PIX_W     = 8;
   localparam int unsigned HCOUNT_W  = 11;
   localparam int unsigned VCOUNT_W  = 10;
   localparam int unsigned ROLE_W    = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } sched_state_t;

   // One beat towards the line buffer prep line.
   typedef struct packed {
      logic [PIX_W-1:0]    pixel;
      logic [HCOUNT_W-1:0] hcount;
      logic [VCOUNT_W-1:0] vcount;
      logic [ROLE_W-1:0]   role;
      logic                kernel_en;
   } buf_beat_t;

   // Line-role rotation 0 -> 1 -> 2 -> 0.
   function automatic logic [ROLE_W-1:0] next_role(input logic [ROLE_W-1:0] role);
      return (role == ROLE_W'(NUM_LINES - 1)) ? '0 : role + ROLE_W'(1);
   endfunction

endpackage

// File: rtl/hv_counter.sv
// Column/row counter shared by the accept and drain paths.
// Holds the coordinate of the next beat; clear_in forces the current beat to (0,0).
module hv_counter
   import dither_pkg::*;
#(
   parameter int unsigned FRAME_WIDTH  = FRAME_WIDTH_DEF,
   parameter int unsigned FRAME_HEIGHT = FRAME_HEIGHT_DEF
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                clear_in,
   input  logic                adv_in,
   output logic [HCOUNT_W-1:0] hcount_c,
   output logic [VCOUNT_W-1:0] vcount_c,
   output logic                line_wrap_c,
   output logic                frame_end_c
);

   logic [HCOUNT_W-1:0] h_q;
   logic [VCOUNT_W-1:0] v_q;

   assign hcount_c    = clear_in ? '0 : h_q;
   assign vcount_c    = clear_in ? '0 : v_q;
   assign line_wrap_c = (hcount_c == HCOUNT_W'(FRAME_WIDTH - 1));
   assign frame_end_c = line_wrap_c & (vcount_c == VCOUNT_W'(FRAME_HEIGHT - 1));

   // Step past the current beat, wrapping the column at end of line.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         h_q <= '0;
         v_q <= '0;
      end else if (adv_in) begin
         if (line_wrap_c) begin
            h_q <= '0;
            v_q <= vcount_c + VCOUNT_W'(1);
         end else begin
            h_q <= hcount_c + HCOUNT_W'(1);
            v_q <= vcount_c;
         end
      end else if (clear_in) begin
         h_q <= '0;
         v_q <= '0;
      end
   end

endmodule

// File: rtl/dither_line_scheduler.sv
// Pixel-stream scheduler for the three-line dither buffer and kernel.
// Optional statistics outputs are enabled with `define DITHER_SCHED_STATS_EN.
module dither_line_scheduler
   import dither_pkg::*;
#(
   parameter int unsigned FRAME_WIDTH  = FRAME_WIDTH_DEF,
   parameter int unsigned FRAME_HEIGHT = FRAME_HEIGHT_DEF,
   parameter logic [7:0]  FILL_PIXEL   = FILL_PIXEL_DEF
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [7:0]  pix_in,
   input  logic        pix_valid_in,
   input  logic        pix_sof_in,
   output logic        pix_ready_out,
   output logic [7:0]  buf_pixel_out,
   output logic [10:0] buf_hcount_out,
   output logic [9:0]  buf_vcount_out,
   output logic        buf_pixel_valid_out,
   output logic [1:0]  role_out,
   output logic        kernel_en_out,
   output logic        busy_out,
   output logic        frame_done_out
`ifdef DITHER_SCHED_STATS_EN
   ,
   output logic [15:0] frame_count_out,
   output logic [7:0]  abort_count_out
`endif
);

   sched_state_t        state_q, state_d;
   logic                ready_en_q;
   logic                accept_c, sof_c, beat_c, kernel_c, drain_last_c;
   logic [HCOUNT_W-1:0] cnt_h_c;
   logic [VCOUNT_W-1:0] cnt_v_c;
   logic                line_wrap_c, frame_end_c;
   logic [ROLE_W-1:0]   role_q, beat_role_c;
   logic                drain_half_q, done_pend_q;
   buf_beat_t           beat_q;

   // Ready depends on state only; held low until the first clock after reset.
   assign pix_ready_out = ready_en_q & (state_q != DRAIN);
   assign accept_c      = pix_valid_in & pix_ready_out;
   assign sof_c         = accept_c & pix_sof_in;
   assign beat_c        = (accept_c & (sof_c | (state_q != IDLE))) | (state_q == DRAIN);
   assign beat_role_c   = sof_c ? '0 : role_q;
   assign drain_last_c  = (state_q == DRAIN) & line_wrap_c & drain_half_q;

   hv_counter #(
      .FRAME_WIDTH  (FRAME_WIDTH),
      .FRAME_HEIGHT (FRAME_HEIGHT)
   ) u_hv_counter (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .clear_in    (sof_c),
      .adv_in      (beat_c),
      .hcount_c    (cnt_h_c),
      .vcount_c    (cnt_v_c),
      .line_wrap_c (line_wrap_c),
      .frame_end_c (frame_end_c)
   );

   // State register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= IDLE;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
      end
   end

   // Next state and kernel enable of the current beat.
   always_comb begin
      state_d  = state_q;
      kernel_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (sof_c) state_d = PRIME;
         end
         PRIME: begin
            if (!sof_c && accept_c && line_wrap_c && (cnt_v_c == VCOUNT_W'(1)))
               state_d = RUN;
         end
         RUN: begin
            kernel_c = ~sof_c;
            if (sof_c)
               state_d = PRIME;
            else if (accept_c && frame_end_c)
               state_d = DRAIN;
         end
         DRAIN: begin
            kernel_c = 1'b1;
            if (drain_last_c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Line-role rotation and drain line tracking.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         role_q       <= '0;
         drain_half_q <= 1'b0;
      end else begin
         if (beat_c)
            role_q <= line_wrap_c ? next_role(beat_role_c) : beat_role_c;
         if (state_q != DRAIN)
            drain_half_q <= 1'b0;
         else if (line_wrap_c)
            drain_half_q <= 1'b1;
      end
   end

   // Registered beat towards the line buffer plus status flags.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         beat_q              <= '0;
         buf_pixel_valid_out <= 1'b0;
         busy_out            <= 1'b0;
         done_pend_q         <= 1'b0;
         frame_done_out      <= 1'b0;
      end else begin
         buf_pixel_valid_out <= beat_c & (state_q != DRAIN);
         if (beat_c) begin
            beat_q.pixel     <= (state_q == DRAIN) ? FILL_PIXEL : pix_in;
            beat_q.hcount    <= cnt_h_c;
            beat_q.vcount    <= cnt_v_c;
            beat_q.role      <= beat_role_c;
            beat_q.kernel_en <= kernel_c;
         end
         busy_out       <= (state_q != IDLE);
         done_pend_q    <= drain_last_c;
         frame_done_out <= done_pend_q;
      end
   end

   assign buf_pixel_out  = beat_q.pixel;
   assign buf_hcount_out = beat_q.hcount;
   assign buf_vcount_out = beat_q.vcount;
   assign role_out       = beat_q.role;
   assign kernel_en_out  = beat_q.kernel_en;

`ifdef DITHER_SCHED_STATS_EN
   // Completed-frame count (wrapping) and mid-frame abort count (saturating).
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         frame_count_out <= '0;
         abort_count_out <= '0;
      end else begin
         if (done_pend_q)
            frame_count_out <= frame_count_out + 16'd1;
         if (sof_c && ((state_q == PRIME) || (state_q == RUN)) && (abort_count_out != 8'hFF))
            abort_count_out <= abort_count_out + 8'd1;
      end
   end
`endif

endmodule
